// File: rtl/monster_field.sv
// Hero-centred monster playfield: monsters spawn in four lanes, step toward the hero on
// each move tick, and are either killed by a matching attack when adjacent or end the game.
module monster_field #(
    parameter int          MONSTERS   = 12,
    parameter int          STEPS      = 3,
    parameter int          SCORE_W    = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [15:0] SPAWN_MASK = 16'h0300,
    localparam int         STEP_W     = ($clog2(STEPS) > 1) ? $clog2(STEPS) : 1,
    localparam int         SLOT_W     = 3 + STEP_W
) (
    input  logic                         clk_game,
    input  logic                         rst_n,
    input  logic                         move_tick,
    input  logic                         power,
    input  logic                         pressing,
    input  logic                         pressed,
    input  logic [1:0]                   state_hero,
    output logic                         start,
    output logic                         game_over,
    output logic [SCORE_W-1:0]           score,
    output logic [MONSTERS*SLOT_W-1:0]   state_monsters
);

    // Encoding chosen so start/game_over are single register bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } game_state_e;

    localparam logic [STEP_W-1:0] DIST_FAR = STEP_W'(STEPS - 1);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               atk_valid_q, atk_valid_d;
    logic [1:0]         atk_dir_q, atk_dir_d;
    logic               alive_q [MONSTERS];
    logic               alive_d [MONSTERS];
    logic [1:0]         dir_q   [MONSTERS];
    logic [1:0]         dir_d   [MONSTERS];
    logic [STEP_W-1:0]  dist_q  [MONSTERS];
    logic [STEP_W-1:0]  dist_d  [MONSTERS];

    logic hit, miss, lane_busy, spawn_en, placed;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // Pre-tick scan of the field: adjacent kills/misses and spawn-lane occupancy.
    always_comb begin
        hit       = 1'b0;
        miss      = 1'b0;
        lane_busy = 1'b0;
        for (int i = 0; i < MONSTERS; i++) begin
            if (alive_q[i] && dist_q[i] == '0) begin
                if (atk_valid_q && atk_dir_q == dir_q[i]) hit = 1'b1;
                else                                      miss = 1'b1;
            end
            if (alive_q[i] && dir_q[i] == lfsr_q[1:0] && dist_q[i] == DIST_FAR)
                lane_busy = 1'b1;
        end
        spawn_en = ((lfsr_q & SPAWN_MASK) == 16'h0000) && !lane_busy && !miss;
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        atk_valid_d = atk_valid_q;
        atk_dir_d   = atk_dir_q;
        alive_d     = alive_q;
        dir_d       = dir_q;
        dist_d      = dist_q;
        placed      = 1'b0;

        if (power) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end else begin
                state_d     = ST_RUN;
                score_d     = '0;
                atk_valid_d = 1'b0;
                atk_dir_d   = 2'b00;
                for (int i = 0; i < MONSTERS; i++) begin
                    alive_d[i] = 1'b0;
                    dir_d[i]   = 2'b00;
                    dist_d[i]  = '0;
                end
            end
        end else if (state_q == ST_RUN) begin
            if (move_tick) begin
                atk_valid_d = 1'b0;
                for (int i = 0; i < MONSTERS; i++) begin
                    if (alive_q[i]) begin
                        if (dist_q[i] != '0)
                            dist_d[i] = dist_q[i] - STEP_W'(1);
                        else if (atk_valid_q && atk_dir_q == dir_q[i])
                            alive_d[i] = 1'b0;
                    end
                end
                if (hit && score_q != '1) score_d = score_q + SCORE_W'(1);
                if (miss) state_d = ST_OVER;
                // Only slots dead before the tick qualify, so a fresh kill is not reused.
                for (int i = 0; i < MONSTERS; i++) begin
                    if (spawn_en && !placed && !alive_q[i]) begin
                        alive_d[i] = 1'b1;
                        dir_d[i]   = lfsr_q[1:0];
                        dist_d[i]  = DIST_FAR;
                        placed     = 1'b1;
                    end
                end
            end
            if (pressing && !pressed) begin
                atk_valid_d = 1'b1;
                atk_dir_d   = state_hero;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking belongs in always_comb.
    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            atk_valid_q <= 1'b0;
            atk_dir_q   <= 2'b00;
            // NOTE: the slot array is reset because it drives a visible output that must read zero.
            for (int i = 0; i < MONSTERS; i++) begin
                alive_q[i] <= 1'b0;
                dir_q[i]   <= 2'b00;
                dist_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lfsr_q      <= lfsr_d;
            atk_valid_q <= atk_valid_d;
            atk_dir_q   <= atk_dir_d;
            alive_q     <= alive_d;
            dir_q       <= dir_d;
            dist_q      <= dist_d;
        end
    end

    assign start     = (state_q == ST_RUN);
    assign game_over = (state_q == ST_OVER);
    assign score     = score_q;

    for (genvar g = 0; g < MONSTERS; g++) begin : g_pack
        assign state_monsters[g*SLOT_W +: SLOT_W] = {dist_q[g], dir_q[g], alive_q[g]};
    end

endmodule

// File: tb/tb_monster_field.sv
// Randomised scoreboard bench for monster_field against a behavioural playfield model.
module tb_monster_field;

    localparam int          MONSTERS = 4;
    localparam int          STEPS    = 3;
    localparam int          SCORE_W  = 2;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [15:0] MASK     = 16'h0100;
    localparam int          STEP_W   = ($clog2(STEPS) > 1) ? $clog2(STEPS) : 1;
    localparam int          SLOT_W   = 3 + STEP_W;
    localparam int          NCYC     = 4000;

    logic                       clk_game   = 1'b0;
    logic                       rst_n      = 1'b0;
    logic                       move_tick  = 1'b0;
    logic                       power      = 1'b0;
    logic                       pressing   = 1'b0;
    logic                       pressed    = 1'b0;
    logic [1:0]                 state_hero = 2'b00;
    logic                       start;
    logic                       game_over;
    logic [SCORE_W-1:0]         score;
    logic [MONSTERS*SLOT_W-1:0] state_monsters;

    monster_field #(
        .MONSTERS   (MONSTERS),
        .STEPS      (STEPS),
        .SCORE_W    (SCORE_W),
        .LFSR_SEED  (SEED),
        .SPAWN_MASK (MASK)
    ) dut (
        .clk_game       (clk_game),
        .rst_n          (rst_n),
        .move_tick      (move_tick),
        .power          (power),
        .pressing       (pressing),
        .pressed        (pressed),
        .state_hero     (state_hero),
        .start          (start),
        .game_over      (game_over),
        .score          (score),
        .state_monsters (state_monsters)
    );

    always #5 clk_game = ~clk_game;

    typedef struct {
        logic                       s;
        logic                       o;
        logic [SCORE_W-1:0]         sc;
        logic [MONSTERS*SLOT_W-1:0] mons;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Behavioural model of the playfield.
    int m_lfsr;
    bit m_start, m_over, m_lv;
    int m_score, m_ldir;
    bit m_alive [MONSTERS];
    int m_dir   [MONSTERS];
    int m_dist  [MONSTERS];

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (fb << 15)) & 32'hFFFF;
    endfunction

    function automatic void model_reset();
        m_lfsr  = int'(SEED);
        m_start = 0;
        m_over  = 0;
        m_score = 0;
        m_lv    = 0;
        m_ldir  = 0;
        for (int i = 0; i < MONSTERS; i++) begin
            m_alive[i] = 0;
            m_dir[i]   = 0;
            m_dist[i]  = 0;
        end
    endfunction

    function automatic void model_cycle();
        bit pre_alive [MONSTERS];
        bit kill, lost, busy;
        int lane;
        kill = 0;
        lost = 0;
        busy = 0;
        if (power) begin
            if (m_start) begin
                m_start = 0;
            end else begin
                model_reset_field();
            end
        end else if (m_start) begin
            if (move_tick) begin
                lane = m_lfsr % 4;
                for (int i = 0; i < MONSTERS; i++) begin
                    pre_alive[i] = m_alive[i];
                    if (m_alive[i] && m_dir[i] == lane && m_dist[i] == STEPS - 1) busy = 1;
                end
                for (int i = 0; i < MONSTERS; i++) begin
                    if (!m_alive[i]) continue;
                    if (m_dist[i] > 0) m_dist[i] = m_dist[i] - 1;
                    else if (m_lv && m_ldir == m_dir[i]) begin m_alive[i] = 0; kill = 1; end
                    else lost = 1;
                end
                if (kill && m_score < (1 << SCORE_W) - 1) m_score = m_score + 1;
                if (lost) begin
                    m_start = 0;
                    m_over  = 1;
                end else if ((m_lfsr & int'(MASK)) == 0 && !busy) begin
                    for (int i = 0; i < MONSTERS; i++) begin
                        if (!pre_alive[i]) begin
                            m_alive[i] = 1;
                            m_dir[i]   = lane;
                            m_dist[i]  = STEPS - 1;
                            break;
                        end
                    end
                end
                m_lv = 0;
            end
            if (pressing && !pressed) begin
                m_lv   = 1;
                m_ldir = int'(state_hero);
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
    endfunction

    function automatic void model_reset_field();
        m_start = 1;
        m_over  = 0;
        m_score = 0;
        m_lv    = 0;
        m_ldir  = 0;
        for (int i = 0; i < MONSTERS; i++) begin
            m_alive[i] = 0;
            m_dir[i]   = 0;
            m_dist[i]  = 0;
        end
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.s    = m_start;
        s.o    = m_over;
        s.sc   = SCORE_W'(m_score);
        s.mons = '0;
        for (int i = 0; i < MONSTERS; i++)
            s.mons[i*SLOT_W +: SLOT_W] = {STEP_W'(m_dist[i]), 2'(m_dir[i]), m_alive[i]};
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: wakes after each clock edge and on an asynchronous reset assertion.
    initial begin
        forever begin
            snap_t e;
            @(posedge clk_game or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("start",          64'(start),          64'(e.s));
                check("game_over",      64'(game_over),      64'(e.o));
                check("score",          64'(score),          64'(e.sc));
                check("state_monsters", 64'(state_monsters), 64'(e.mons));
            end
        end
    end

    // Driver: picks inputs on the falling edge, advances the model, queues the expectation.
    initial begin
        int  rel_at;
        int  quiet_until;
        bit  mid_done;
        int  pick;
        rel_at      = 3;
        quiet_until = 0;
        mid_done    = 0;
        model_reset();
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk_game);
            if (c == rel_at) rst_n = 1'b1;

            if (!mid_done && c >= 2000 && rst_n && m_start) begin
                mid_done    = 1;
                rel_at      = c + 3;
                quiet_until = c + 15;
                power       = 1'b0;
                move_tick   = 1'b0;
                #2;
                rst_n = 1'b0;
                model_reset();
                exp_q.push_back(model_snap());
                continue;
            end

            if (!rst_n) begin
                power     = 1'b0;
                move_tick = 1'b0;
                pressed   = pressing;
                pressing  = 1'b0;
                model_reset();
                exp_q.push_back(model_snap());
                continue;
            end

            pressed  = pressing;
            pressing = ($urandom_range(0, 2) == 0);
            pick     = -1;
            for (int i = 0; i < MONSTERS; i++)
                if (m_alive[i] && m_dist[i] <= 1 && pick < 0) pick = i;
            if (pick >= 0 && $urandom_range(0, 4) != 0) state_hero = 2'(m_dir[pick]);
            else                                        state_hero = 2'($urandom_range(0, 3));

            power = 1'b0;
            if (c >= quiet_until) begin
                if (!m_start && $urandom_range(0, 7) == 0)        power = 1'b1;
                else if (m_start && $urandom_range(0, 199) == 0)  power = 1'b1;
            end
            move_tick = !power && ($urandom_range(0, 2) == 0);

            model_cycle();
            exp_q.push_back(model_snap());
        end
        @(negedge clk_game);
        power     = 1'b0;
        move_tick = 1'b0;
        repeat (2) @(posedge clk_game);
        #2;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
